// File: rtl/cacheline_adaptor.sv
// Cache-line (256-bit) to 4x64-bit burst adaptor: IDLE -> READ/WRITE -> DONE.
// Optional burst-side watchdog enabled by defining CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         line_read,
    input  logic         line_write,
    input  logic [31:0]  line_address,
    input  logic [255:0] line_wdata,
    output logic [255:0] line_rdata,
    output logic         line_resp,
    output logic         line_error,
    output logic [31:0]  burst_address,
    output logic         burst_read,
    output logic         burst_write,
    output logic [63:0]  burst_wdata,
    input  logic [63:0]  burst_rdata,
    input  logic         burst_resp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [1:0]    beat_r;
    logic [31:0]   addr_r;
    logic [255:0]  wdata_r;
    logic [255:0]  rdata_r;
    logic          error_r;
    logic          timeout_s;
    logic          unused_addr_s;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cacheline_adaptor: TIMEOUT_CYCLES must be at least 1");
    end

    // Line offset bits never reach the burst side.
    assign unused_addr_s = ^line_address[4:0];

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_r;

    // Watchdog: counts burst-side cycles since the last beat, cleared outside READ/WRITE
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if ((state_r == READ || state_r == WRITE) && !burst_resp) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= '0;
        end
    end

    assign timeout_s = (state_r == READ || state_r == WRITE) && !burst_resp &&
                       (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (line_read) begin
                    state_s = READ;
                end else if (line_write) begin
                    state_s = WRITE;
                end else begin
                    state_s = IDLE;
                end
            end
            READ, WRITE: begin
                if (burst_resp && (beat_r == 2'd3)) begin
                    state_s = DONE;
                end else if (timeout_s) begin
                    state_s = DONE;
                end else begin
                    state_s = state_r;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, request latches, beat counter and read line assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            beat_r  <= 2'd0;
            addr_r  <= 32'd0;
            wdata_r <= 256'd0;
            rdata_r <= 256'd0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_s;
            error_r <= timeout_s;
            case (state_r)
                IDLE: begin
                    beat_r <= 2'd0;
                    if (line_read || line_write) begin
                        addr_r  <= {line_address[31:5], 5'b0};
                        wdata_r <= line_wdata;
                    end
                end
                READ: begin
                    if (burst_resp) begin
                        rdata_r[{beat_r, 6'd0} +: 64] <= burst_rdata;
                        beat_r <= beat_r + 2'd1;
                    end
                end
                WRITE: begin
                    if (burst_resp) begin
                        beat_r <= beat_r + 2'd1;
                    end
                end
                default: beat_r <= 2'd0;
            endcase
        end
    end

    assign burst_read    = (state_r == READ);
    assign burst_write   = (state_r == WRITE);
    assign line_resp     = (state_r == DONE);
    assign line_error    = error_r;
    assign burst_address = addr_r;
    assign burst_wdata   = wdata_r[{beat_r, 6'd0} +: 64];
    assign line_rdata    = rdata_r;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor against a transaction-level model:
// expected line data is assembled from the beats the bench itself supplies.
module tb_cacheline_adaptor;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic         clk;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic         line_error;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int total = 0;
    int bad   = 0;
    logic [255:0] exp_rdata;

    cacheline_adaptor #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_address  (line_address),
        .line_wdata    (line_wdata),
        .line_rdata    (line_rdata),
        .line_resp     (line_resp),
        .line_error    (line_error),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_brd"},  256'(burst_read),  '0);
        chk({tag, "_bwr"},  256'(burst_write), '0);
        chk({tag, "_resp"}, 256'(line_resp),   '0);
        chk({tag, "_err"},  256'(line_error),  '0);
        chk({tag, "_rdata"}, line_rdata, exp_rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            idle_check("idle");
            burst_resp  = 1'($urandom_range(0, 1));
            burst_rdata = {$urandom, $urandom};
            @(negedge clk);
        end
        burst_resp = 1'b0;
    endtask

    // mode: 0 random beats (never 3 misses in a row), 1 every cycle, 2 even cycles only
    // hold: 0 drop after accept, 1 hold until line_resp, 2 hold past line_resp
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [255:0] wdata, input int mode,
                           input bit use_pat, input logic [255:0] pat, input int hold);
        bit          rd_eff;
        bit          resp;
        logic [31:0] exp_addr;
        logic [63:0] beat;
        int          k;
        int          cyc;
        int          misses;
        rd_eff   = rd;
        exp_addr = {addr[31:5], 5'b0};
        idle_check("pre");
        line_read    = rd;
        line_write   = wr;
        line_address = addr;
        line_wdata   = wdata;
        burst_resp   = 1'b0;
        @(negedge clk);
        cyc = 1;
        if (hold == 0) begin
            line_read    = 1'b0;
            line_write   = 1'b0;
            line_address = $urandom;
            line_wdata   = {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
        end
        k = 0;
        misses = 0;
        while (k < 4 && cyc < 60) begin
            chk("brd",   256'(burst_read),    256'(rd_eff));
            chk("bwr",   256'(burst_write),   256'(!rd_eff));
            chk("baddr", 256'(burst_address), 256'(exp_addr));
            chk("early_resp", 256'(line_resp), '0);
            if (!rd_eff) chk("bwdata", 256'(burst_wdata), 256'(wdata[64*k +: 64]));
            case (mode)
                1:       resp = 1'b1;
                2:       resp = (cyc % 2 == 0);
                default: resp = ($urandom_range(0, 1) == 1) || (misses >= 2);
            endcase
            misses = resp ? 0 : misses + 1;
            beat = use_pat ? pat[64*k +: 64] : {$urandom, $urandom};
            burst_resp  = resp;
            burst_rdata = beat;
            if (rd_eff && resp) exp_rdata[64*k +: 64] = beat;
            @(negedge clk);
            cyc++;
            if (resp) k++;
        end
        chk("beats_bound", 256'(k), 256'(4));
        burst_resp  = 1'($urandom_range(0, 1));
        burst_rdata = {$urandom, $urandom};
        chk("line_resp",  256'(line_resp),   256'(1));
        chk("line_error", 256'(line_error),  '0);
        chk("done_brd",   256'(burst_read),  '0);
        chk("done_bwr",   256'(burst_write), '0);
        chk("line_rdata", line_rdata, exp_rdata);
        if (mode == 1) chk("latency", 256'(cyc), 256'(5));
        if (hold == 1) begin
            line_read  = 1'b0;
            line_write = 1'b0;
        end
        @(negedge clk);
        burst_resp = 1'b0;
        idle_check("post");
    endtask

    logic [255:0] pat31;
    logic [255:0] wd32;
    logic [31:0]  ra;
    bit           rr;
    bit           rw;
    int           cyc;

    initial begin
        pat31 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        wd32  = {64'd4, 64'd3, 64'd2, 64'd1};
        rst = 1'b1; line_read = 1'b0; line_write = 1'b0;
        line_address = 32'd0; line_wdata = 256'd0;
        burst_rdata = 64'd0; burst_resp = 1'b0;
        exp_rdata = 256'd0;
        @(negedge clk);
        @(negedge clk);
        idle_check("reset");
        chk("reset_baddr",  256'(burst_address), '0);
        chk("reset_bwdata", 256'(burst_wdata),   '0);
        rst = 1'b0;
        @(negedge clk);

        // Known-beat read, back-to-back responses
        run_txn(1'b1, 1'b0, 32'h0000_1234, 256'd0, 1, 1'b1, pat31, 0);
        chk("r031_rdata", line_rdata, pat31);
        idle(2);

        // Write with responses on alternate cycles only
        run_txn(1'b0, 1'b1, 32'h8000_0040, wd32, 2, 1'b0, 256'd0, 0);
        idle(1);

        // Read and write together: read wins
        run_txn(1'b1, 1'b1, $urandom, {8{$urandom}}, 0, 1'b0, 256'd0, 0);
        idle(1);

        // Request held past line_resp re-issues exactly once; dropped with line_resp gives none
        ra = $urandom;
        run_txn(1'b1, 1'b0, ra, 256'd0, 1, 1'b0, 256'd0, 2);
        run_txn(1'b1, 1'b0, ra, 256'd0, 1, 1'b0, 256'd0, 1);
        idle(3);

        // Reset after two read beats
        line_read = 1'b1;
        line_address = 32'hABCD_EF00;
        @(negedge clk);
        line_read = 1'b0;
        repeat (2) begin
            burst_resp  = 1'b1;
            burst_rdata = {$urandom, $urandom};
            @(negedge clk);
        end
        burst_resp = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        exp_rdata = 256'd0;
        idle_check("midrst");
        chk("midrst_baddr", 256'(burst_address), '0);
        rst = 1'b0;
        @(negedge clk);
        idle_check("after_rst");
        run_txn(1'b1, 1'b0, $urandom, 256'd0, 1, 1'b0, 256'd0, 0);
        idle(1);

        // Random traffic
        repeat (30) begin
            rr = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            if (!rr && !rw) rw = 1'b1;
            run_txn(rr, rw, $urandom,
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 2), 1'b0, 256'd0, $urandom_range(0, 1));
            idle($urandom_range(0, 2));
        end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        // Read with no burst response aborts after TO silent cycles
        line_read = 1'b1;
        line_address = $urandom;
        @(negedge clk);
        line_read = 1'b0;
        cyc = 1;
        while (line_resp !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_latency", 256'(cyc), 256'(TO + 1));
        chk("to_resp",  256'(line_resp),  256'(1));
        chk("to_error", 256'(line_error), 256'(1));
        chk("to_rdata", line_rdata, exp_rdata);
        @(negedge clk);
        idle_check("to_post");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
